// File: rtl/mcu_spi_master.sv
// SPI master, mode 1 (CPOL=0, CPHA=1), MSB first. Each transaction sends a target byte
// followed by one or more payload bytes pulled through a valid/ready handshake.
module mcu_spi_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_start,
  input  logic [7:0] cmd_target,
  output logic       cmd_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       spi_io_ss,
  output logic       spi_io_clk,
  output logic       spi_io_din,
  input  logic       spi_io_dout
);

  localparam int unsigned CntMax = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(CS_GAP - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StWait,
    StHold,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      byte_q, byte_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            last_q, last_d;
  logic            payload_q, payload_d;
  logic            have_q, have_d;
  logic            ss_q, ss_d;
  logic            sck_q, sck_d;
  logic            din_q, din_d;

  logic            tick;
  logic            hs;
  logic [7:0]      rx_next;

  assign tick    = (cnt_q == DivLast);
  assign tx_ready = (state_q == StWait) && !have_q;
  assign hs      = tx_valid && tx_ready;
  assign rx_next = {rx_shift_q[6:0], spi_io_dout};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last_d     = last_q;
    payload_d  = payload_q;
    have_d     = have_q;
    ss_d       = ss_q;
    sck_d      = sck_q;
    din_d      = din_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (cmd_start) begin
          byte_d    = cmd_target;
          payload_d = 1'b0;
          last_d    = 1'b0;
          have_d    = 1'b0;
          ss_d      = 1'b0;
          state_d   = StSetup;
        end
      end

      StSetup: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          sck_d   = 1'b1;
          din_d   = byte_q[7];
          state_d = StShift;
        end
      end

      StShift: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d = '0;
          if (sck_q) begin
            sck_d      = 1'b0;
            rx_shift_d = rx_next;
            bit_d      = bit_q + 1'b1;
            if (bit_q == 3'd7) begin
              // Bits clocked in during the target byte are never reported.
              if (payload_q) begin
                rx_data_d  = rx_next;
                rx_valid_d = 1'b1;
              end
              state_d = last_q ? StHold : StWait;
            end
          end else begin
            sck_d = 1'b1;
            din_d = byte_q[~bit_q];
          end
        end
      end

      StWait: begin
        // Saturate so a late handshake can launch the next byte immediately.
        if (!tick) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (hs) begin
          byte_d    = tx_data;
          last_d    = tx_last;
          payload_d = 1'b1;
          have_d    = 1'b1;
        end
        if ((hs || have_q) && tick) begin
          cnt_d   = '0;
          have_d  = 1'b0;
          sck_d   = 1'b1;
          din_d   = hs ? tx_data[7] : byte_q[7];
          state_d = StShift;
        end
      end

      StHold: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d   = '0;
          ss_d    = 1'b1;
          din_d   = 1'b0;
          state_d = StGap;
        end
      end

      StGap: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      last_q     <= 1'b0;
      payload_q  <= 1'b0;
      have_q     <= 1'b0;
      ss_q       <= 1'b1;
      sck_q      <= 1'b0;
      din_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      last_q     <= last_d;
      payload_q  <= payload_d;
      have_q     <= have_d;
      ss_q       <= ss_d;
      sck_q      <= sck_d;
      din_q      <= din_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign spi_io_ss  = ss_q;
  assign spi_io_clk = sck_q;
  assign spi_io_din = din_q;

endmodule

// File: tb/tb_mcu_spi_master.sv
// Bench for mcu_spi_master: a bus monitor decodes SCK/MOSI against expected byte queues and
// timing rules every cycle; directed tests pin exact latencies and counts.
module tb_mcu_spi_master;

  localparam int DIV = 2;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_start = 1'b0;
  logic [7:0] cmd_target = 8'h00;
  logic       cmd_ready;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_io_ss;
  logic       spi_io_clk;
  logic       spi_io_din;
  logic       spi_io_dout = 1'b0;

  mcu_spi_master #(
    .CLK_DIV(DIV),
    .CS_GAP (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_start  (cmd_start),
    .cmd_target (cmd_target),
    .cmd_ready  (cmd_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .spi_io_ss  (spi_io_ss),
    .spi_io_clk (spi_io_clk),
    .spi_io_din (spi_io_din),
    .spi_io_dout(spi_io_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: bytes expected on MOSI and bytes expected on rx_data, in order.
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];
  logic [7:0] miso_arr[4];
  bit         stream_mode = 1'b0;

  int mon_rises = 0;
  int mon_rxv = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int ss_rise_cyc = 0;
  int rdy_rise_cyc = 0;

  // Slave: shifts its response MSB first, updating MISO on each SCK rising edge.
  initial begin
    logic [1:0] s_byte;
    logic [2:0] s_bit;
    s_byte = '0;
    s_bit  = '0;
    forever begin
      @(posedge spi_io_clk or posedge spi_io_ss);
      if (spi_io_ss) begin
        s_byte = '0;
        s_bit  = '0;
      end else begin
        spi_io_dout = miso_arr[s_byte][~s_bit];
        if (s_bit == 3'd7) s_byte = s_byte + 1'b1;
        s_bit = s_bit + 1'b1;
      end
    end
  end

  // Monitor: checks bus protocol and timing against the transaction-level model.
  initial begin
    bit         rise, fall, prev_sck, prev_ss, prev_rdy, prev_rxv;
    int         lo_len, hi_len, bitn, rise_n, fall_n, expb;
    logic [7:0] mosi_sh, last_rx;
    prev_sck = 0; prev_ss = 1; prev_rdy = 1; prev_rxv = 0;
    lo_len = 0; hi_len = 0; bitn = 0; rise_n = 0; fall_n = 0;
    mosi_sh = '0; last_rx = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        prev_sck = 0; prev_ss = 1; prev_rdy = 1; prev_rxv = 0;
        lo_len = 0; hi_len = 0; bitn = 0; rise_n = 0; fall_n = 0; last_rx = '0;
      end else begin
        rise = spi_io_clk && !prev_sck;
        fall = !spi_io_clk && prev_sck;
        chk_eq("ready_vs_busy", cmd_ready, !busy);
        if (tx_ready) chk_eq("tx_ready_needs_busy", busy, 1);
        if (spi_io_ss) begin
          chk_eq("sck_idle_low", spi_io_clk, 0);
          chk_eq("din_idle_low", spi_io_din, 0);
        end
        if (prev_ss && !spi_io_ss) begin
          lo_len = 0; bitn = 0; rise_n = 0; fall_n = 0;
        end
        if (!spi_io_ss) begin
          if (rise) begin
            if (rise_n == 0) chk_eq("setup_len", lo_len, DIV);
            else if (bitn != 0) chk_eq("sck_low_len", lo_len, DIV);
            else if (stream_mode) chk_eq("byte_gap_stream", lo_len, DIV);
            else chk_eq("byte_gap_min", int'(lo_len >= DIV), 1);
            lo_len = 0; hi_len = 1; rise_n++; mon_rises++;
            mosi_sh = {mosi_sh[6:0], spi_io_din};
            bitn++;
            if (bitn == 8) begin
              bitn = 0;
              expb = (exp_mosi.size() != 0) ? int'(exp_mosi.pop_front()) : 256;
              chk_eq("mosi_byte", mosi_sh, expb);
            end
          end else if (fall) begin
            chk_eq("sck_high_len", hi_len, DIV);
            hi_len = 0; lo_len = 1; fall_n++;
            last_fall_cyc = cyc;
          end else if (spi_io_clk) begin
            hi_len++;
          end else begin
            lo_len++;
          end
        end
        if (rx_valid) begin
          mon_rxv++;
          chk_eq("rxv_after_payload_fall", int'(fall && fall_n % 8 == 0 && fall_n > 8), 1);
          chk_eq("rxv_one_cycle", prev_rxv, 0);
          expb = (exp_rx.size() != 0) ? int'(exp_rx.pop_front()) : 256;
          chk_eq("rx_data", rx_data, expb);
          last_rx = rx_data;
        end else begin
          chk_eq("rx_data_hold", rx_data, last_rx);
        end
        if (!prev_ss && spi_io_ss) ss_rise_cyc = cyc;
        if (cmd_ready && !prev_rdy) rdy_rise_cyc = cyc;
        prev_sck = spi_io_clk; prev_ss = spi_io_ss; prev_rdy = cmd_ready; prev_rxv = rx_valid;
      end
    end
  end

  task automatic load_txn(input logic [7:0] tgt, input int n, input logic [7:0] p0,
                          input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] r0,
                          input logic [7:0] r1, input logic [7:0] r2);
    logic [7:0] pay[3];
    logic [7:0] rsp[3];
    pay = '{p0, p1, p2};
    rsp = '{r0, r1, r2};
    exp_mosi.push_back(tgt);
    miso_arr[0] = 8'hFF;
    for (int i = 0; i < n; i++) begin
      exp_mosi.push_back(pay[i]);
      exp_rx.push_back(rsp[i]);
      miso_arr[i+1] = rsp[i];
    end
  endtask

  task automatic wait_ready(input string name);
    int t;
    t = 0;
    while (!cmd_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk_eq(name, cmd_ready, 1);
  endtask

  task automatic start_cmd(input logic [7:0] tgt);
    wait_ready("cmd_ready_timeout");
    cmd_target = tgt;
    cmd_start  = 1'b1;
    @(negedge clk);
    cmd_start  = 1'b0;
  endtask

  // Offers one payload byte and returns at the negedge after the handshake edge.
  task automatic send_byte(input logic [7:0] d, input bit last);
    int t;
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk_eq("tx_ready_timeout", tx_ready, 1);
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [7:0] tgt, input int n, input logic [7:0] p0,
                         input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] r0,
                         input logic [7:0] r1, input logic [7:0] r2);
    logic [7:0] pay[3];
    pay = '{p0, p1, p2};
    load_txn(tgt, n, p0, p1, p2, r0, r1, r2);
    start_cmd(tgt);
    for (int i = 0; i < n; i++) send_byte(pay[i], i == n - 1);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    wait_ready("txn_done_timeout");
    @(negedge clk);
    chk_eq("mosi_queue_drained", exp_mosi.size(), 0);
    chk_eq("rx_queue_drained", exp_rx.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_r, base_v, t;

    // Reset held with requests asserted: everything stays idle.
    cmd_start = 1'b1;
    cmd_target = 8'h5E;
    tx_valid = 1'b1;
    tx_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("rst_ss", spi_io_ss, 1);
      chk_eq("rst_sck", spi_io_clk, 0);
      chk_eq("rst_din", spi_io_din, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_cmd_ready", cmd_ready, 1);
      chk_eq("rst_tx_ready", tx_ready, 0);
      chk_eq("rst_rx_valid", rx_valid, 0);
      chk_eq("rst_rx_data", rx_data, 0);
    end
    cmd_start = 1'b0;
    tx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Single transaction: target 0x02, payload 0xA5, slave answers 0x3C.
    base_r = mon_rises;
    base_v = mon_rxv;
    run_txn(8'h02, 1, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
    chk_eq("single_rises", mon_rises - base_r, 16);
    chk_eq("single_rxv_count", mon_rxv - base_v, 1);
    chk_eq("single_rx_data", rx_data, 8'h3C);
    chk_eq("single_ss_after_fall", ss_rise_cyc - last_fall_cyc, 2);
    chk_eq("single_ready_after_ss", rdy_rise_cyc - ss_rise_cyc, 4);

    // Streaming three payload bytes with tx_valid held high.
    stream_mode = 1'b1;
    base_r = mon_rises;
    base_v = mon_rxv;
    run_txn(8'h01, 3, 8'h11, 8'h22, 8'h33, 8'h9A, 8'h4B, 8'hE7);
    stream_mode = 1'b0;
    chk_eq("stream_rises", mon_rises - base_r, 32);
    chk_eq("stream_rxv_count", mon_rxv - base_v, 3);
    chk_eq("stream_rx_last", rx_data, 8'hE7);

    // Stall for 20 cycles after the target byte.
    base_r = mon_rises;
    load_txn(8'hC6, 1, 8'h5A, 8'h00, 8'h00, 8'hC3, 8'h00, 8'h00);
    start_cmd(8'hC6);
    t = 0;
    while (!tx_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk_eq("stall_wait_entry", tx_ready, 1);
    for (int i = 0; i < 20; i++) begin
      chk_eq("stall_ss_low", spi_io_ss, 0);
      chk_eq("stall_sck_low", spi_io_clk, 0);
      chk_eq("stall_tx_ready", tx_ready, 1);
      @(negedge clk);
    end
    tx_data = 8'h5A;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    @(negedge clk);
    chk_eq("stall_rise_after_hs", spi_io_clk, 1);
    chk_eq("stall_rise_count", mon_rises - base_r, 9);
    tx_valid = 1'b0;
    tx_last = 1'b0;
    wait_ready("stall_done_timeout");
    chk_eq("stall_rx_data", rx_data, 8'hC3);

    // Reset after the 4th rising edge of the payload byte.
    base_r = mon_rises;
    base_v = mon_rxv;
    load_txn(8'h0F, 1, 8'hF0, 8'h00, 8'h00, 8'h66, 8'h00, 8'h00);
    start_cmd(8'h0F);
    tx_data = 8'hF0;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    t = 0;
    while (mon_rises - base_r < 12 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk_eq("midrst_reach_rise12", mon_rises - base_r, 12);
    tx_valid = 1'b0;
    tx_last = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk_eq("midrst_ss", spi_io_ss, 1);
    chk_eq("midrst_sck", spi_io_clk, 0);
    chk_eq("midrst_rx_valid", rx_valid, 0);
    chk_eq("midrst_busy", busy, 0);
    exp_mosi.delete();
    exp_rx.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_eq("midrst_no_rxv", mon_rxv - base_v, 0);
    run_txn(8'h3A, 1, 8'h81, 8'h00, 8'h00, 8'h7E, 8'h00, 8'h00);
    chk_eq("midrst_after_rxv", mon_rxv - base_v, 1);
    chk_eq("midrst_after_rx_data", rx_data, 8'h7E);

    // cmd_start with target 0x07 during SHIFT must be ignored.
    load_txn(8'h44, 1, 8'h99, 8'h00, 8'h00, 8'h5D, 8'h00, 8'h00);
    start_cmd(8'h44);
    tx_data = 8'h99;
    tx_last = 1'b1;
    tx_valid = 1'b1;
    t = 0;
    while (!spi_io_clk && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk_eq("busy_in_shift", busy, 1);
    chk_eq("busy_cmd_ready", cmd_ready, 0);
    cmd_target = 8'h07;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    send_byte(8'h99, 1'b1);
    tx_valid = 1'b0;
    tx_last = 1'b0;
    wait_ready("busy_done_timeout");
    chk_eq("busy_rx_data", rx_data, 8'h5D);
    run_txn(8'h21, 1, 8'h12, 8'h00, 8'h00, 8'h6D, 8'h00, 8'h00);
    chk_eq("busy_next_rx_data", rx_data, 8'h6D);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
